alu_exec_unit: RTL and testbench

Fetch-and-execute slice of the single-cycle processor. It combines a word-addressed instruction memory, the ALU-control decoder that maps opcode/funct to a 4-bit ALU operation, and a 32-bit behavioural ALU. Read, decode and execute paths are purely combinational. The clock is used only for the program-load write port and a registered status flag register.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 58 +++++
 rtl/alu_ctrl_dec.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 87 ++++++++
 tb/tb_alu_exec_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the fetch/execute slice.
// ALU operation codes, opcode/funct values, NOP word and flag bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_ADDU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SUBU = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SLL  = 4'd10;
    localparam logic [3:0] ALU_SRL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_LUI  = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic illegal;
        logic overflow;
        logic carry_out;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// 32-bit behavioural ALU with carry, overflow and zero flags.
// Ports: a, b, sa, op, carry_in -> result, overflow, carry_out, zero.
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  sa,
    input  logic [3:0]  op,
    input  logic        carry_in,
    output logic [31:0] result,
    output logic        overflow,
    output logic        carry_out,
    output logic        zero
);

    logic [32:0] sum;
    logic [31:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};
        diff = a - b;
    end

    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        unique case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_ADD, ALU_ADDU: begin
                result    = sum[31:0];
                carry_out = sum[32];
                overflow  = (op == ALU_ADD) && (a[31] == b[31])
                            && (sum[31] != a[31]);
            end
            ALU_SUB, ALU_SUBU: begin
                result    = diff;
                // carry doubles as "no borrow"
                carry_out = (a >= b);
                overflow  = (op == ALU_SUB) && (a[31] != b[31])
                            && (diff[31] != a[31]);
            end
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_SLL:  result = b << sa;
            ALU_SRL:  result = b >> sa;
            ALU_SRA:  result = $unsigned($signed(b) >>> sa);
            ALU_LUI:  result = {b[15:0], 16'h0};
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: opcode/funct -> alu_op, illegal, shift source.
// sa_var=1 selects busA[4:0] as shift amount instead of shamt.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic       sa_var
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        sa_var  = 1'b0;
        if (opcode == OP_RTYPE) begin
            unique case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_ADDU: alu_op = ALU_ADDU;
                FN_SUB:  alu_op = ALU_SUB;
                FN_SUBU: alu_op = ALU_SUBU;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SLTU: alu_op = ALU_SLTU;
                FN_SLL:  alu_op = ALU_SLL;
                FN_SRL:  alu_op = ALU_SRL;
                FN_SRA:  alu_op = ALU_SRA;
                FN_SLLV: begin
                    alu_op = ALU_SLL;
                    sa_var = 1'b1;
                end
                FN_SRLV: begin
                    alu_op = ALU_SRL;
                    sa_var = 1'b1;
                end
                FN_SRAV: begin
                    alu_op = ALU_SRA;
                    sa_var = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            unique case (opcode)
                OP_ADDI:        alu_op = ALU_ADD;
                OP_ADDIU:       alu_op = ALU_ADDU;
                OP_SLTI:        alu_op = ALU_SLT;
                OP_SLTIU:       alu_op = ALU_SLTU;
                OP_ANDI:        alu_op = ALU_AND;
                OP_ORI:         alu_op = ALU_OR;
                OP_XORI:        alu_op = ALU_XOR;
                OP_LUI:         alu_op = ALU_LUI;
                OP_BEQ, OP_BNE: alu_op = ALU_SUB;
                OP_LW, OP_SW:   alu_op = ALU_ADD;
                default:        illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Fetch/execute slice: instruction memory, ALU decode and ALU.
// Ports: CLK, masterReset, pc, imem write port, busA/busB, ALU outputs, flags_q.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic               CLK,
    input  logic               masterReset,
    input  logic [31:0]        pc,
    output logic [31:0]        instruction,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic [31:0]        busA,
    input  logic [31:0]        busB,
    input  logic               carry_in,
    output logic [3:0]         alu_op,
    output logic [31:0]        alu_out,
    output logic               overflow,
    output logic               carry_out,
    output logic               zero,
    output logic               illegal,
    output logic [3:0]         flags_q
);

    logic [31:0] imem [IMEM_DEPTH];
    logic        sa_var;
    logic [4:0]  sa;
    logic [3:0]  flags_d;
    logic        unused_pc;

    // byte offset within the word is not decoded
    assign unused_pc = ^pc[1:0];

    always_ff @(posedge CLK) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        if (pc[31:IMEM_AW+2] == '0) begin
            instruction = imem[pc[IMEM_AW+1:2]];
        end else begin
            instruction = NOP;
        end
    end

    alu_ctrl_dec u_dec (
        .opcode  (instruction[31:26]),
        .funct   (instruction[5:0]),
        .alu_op  (alu_op),
        .illegal (illegal),
        .sa_var  (sa_var)
    );

    always_comb begin
        sa = sa_var ? busA[4:0] : instruction[10:6];
    end

    alu_core u_core (
        .a         (busA),
        .b         (busB),
        .sa        (sa),
        .op        (alu_op),
        .carry_in  (carry_in),
        .result    (alu_out),
        .overflow  (overflow),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always_comb begin
        flags_d = {illegal, overflow, carry_out, zero};
    end

    always_ff @(posedge CLK) begin
        if (masterReset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit.
// Random programs checked against a behavioural reference model.
module tb_alu_exec_unit;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          CLK = 1'b0;
    logic          masterReset;
    logic [31:0]   pc;
    logic [31:0]   instruction;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   busA;
    logic [31:0]   busB;
    logic          carry_in;
    logic [3:0]    alu_op;
    logic [31:0]   alu_out;
    logic          overflow;
    logic          carry_out;
    logic          zero;
    logic          illegal;
    logic [3:0]    flags_q;

    alu_exec_unit #(.IMEM_DEPTH(DEPTH), .IMEM_AW(AW)) dut (
        .CLK         (CLK),
        .masterReset (masterReset),
        .pc          (pc),
        .instruction (instruction),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .busA        (busA),
        .busB        (busB),
        .carry_in    (carry_in),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .overflow    (overflow),
        .carry_out   (carry_out),
        .zero        (zero),
        .illegal     (illegal),
        .flags_q     (flags_q)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] smem [DEPTH];
    logic [3:0]  exp_flags;

    logic [5:0] r_fn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h04,
                              6'h02, 6'h06, 6'h03, 6'h07};
    logic [5:0] i_op [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h0F, 6'h04, 6'h05, 6'h23, 6'h2B};
    logic [31:0] corner [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode by table, execute with wide signed/unsigned math.
    function automatic void model(
        input  logic [31:0] ins, a, b,
        input  logic        cin,
        output logic [3:0]  op,
        output logic        ill,
        output logic [31:0] r,
        output logic        ov,
        output logic        co
    );
        logic [5:0] opc;
        logic [5:0] fn;
        int         sh;
        longint     s;
        longint     sv;
        opc = ins[31:26];
        fn  = ins[5:0];
        sh  = int'(ins[10:6]);
        op  = 4'd2;
        ill = 1'b0;
        if (opc == 6'h00) begin
            case (fn)
                6'h20: op = 4'd2;
                6'h21: op = 4'd3;
                6'h22: op = 4'd6;
                6'h23: op = 4'd8;
                6'h24: op = 4'd0;
                6'h25: op = 4'd1;
                6'h26: op = 4'd4;
                6'h27: op = 4'd5;
                6'h2A: op = 4'd7;
                6'h2B: op = 4'd9;
                6'h00: op = 4'd10;
                6'h02: op = 4'd11;
                6'h03: op = 4'd12;
                6'h04: begin op = 4'd10; sh = int'(a[4:0]); end
                6'h06: begin op = 4'd11; sh = int'(a[4:0]); end
                6'h07: begin op = 4'd12; sh = int'(a[4:0]); end
                default: ill = 1'b1;
            endcase
        end else begin
            case (opc)
                6'h08, 6'h23, 6'h2B: op = 4'd2;
                6'h09: op = 4'd3;
                6'h0A: op = 4'd7;
                6'h0B: op = 4'd9;
                6'h0C: op = 4'd0;
                6'h0D: op = 4'd1;
                6'h0E: op = 4'd4;
                6'h0F: op = 4'd13;
                6'h04, 6'h05: op = 4'd6;
                default: ill = 1'b1;
            endcase
        end
        r  = '0;
        ov = 1'b0;
        co = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd2, 4'd3: begin
                s  = longint'({32'b0, a}) + longint'({32'b0, b})
                     + longint'({63'b0, cin});
                r  = s[31:0];
                co = s[32];
                sv = longint'($signed(a)) + longint'($signed(b))
                     + longint'({63'b0, cin});
                ov = (op == 4'd2) && (sv > 64'sd2147483647
                                      || sv < -64'sd2147483648);
            end
            4'd6, 4'd8: begin
                sv = longint'($signed(a)) - longint'($signed(b));
                s  = longint'({32'b0, a}) - longint'({32'b0, b});
                r  = s[31:0];
                co = (s >= 0);
                ov = (op == 4'd6) && (sv > 64'sd2147483647
                                      || sv < -64'sd2147483648);
            end
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = b << sh;
            4'd11: r = b >> sh;
            4'd12: r = $unsigned($signed(b) >>> sh);
            4'd13: r = {b[15:0], 16'h0};
            default: r = '0;
        endcase
    endfunction

    function automatic logic [31:0] exp_ins();
        return (pc[31:10] == 22'b0) ? smem[pc[9:2]] : 32'h0;
    endfunction

    task automatic tick();
        logic [3:0]  op;
        logic        ill, ov, co;
        logic [31:0] r;
        logic [3:0]  nxt;
        model(exp_ins(), busA, busB, carry_in, op, ill, r, ov, co);
        nxt = masterReset ? 4'h0 : {ill, ov, co, r == 32'h0};
        @(posedge CLK);
        if (imem_we) smem[imem_waddr] = imem_wdata;
        exp_flags = nxt;
        #1;
    endtask

    task automatic check_comb(input string tag);
        logic [3:0]  op;
        logic        ill, ov, co;
        logic [31:0] r;
        #1;
        model(exp_ins(), busA, busB, carry_in, op, ill, r, ov, co);
        chk({tag, ".ins"}, instruction, exp_ins());
        chk({tag, ".op"}, {28'b0, alu_op}, {28'b0, op});
        chk({tag, ".out"}, alu_out, r);
        chk({tag, ".flags"}, {28'b0, illegal, overflow, carry_out, zero},
            {28'b0, ill, ov, co, r == 32'h0});
    endtask

    task automatic run(input string tag, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
        logic [AW-1:0] w;
        w          = AW'($urandom);
        imem_we    = 1'b1;
        imem_waddr = w;
        imem_wdata = ins;
        tick();
        imem_we    = 1'b0;
        pc         = {22'b0, w, 2'($urandom)};
        busA       = a;
        busB       = b;
        carry_in   = cin;
        check_comb(tag);
        tick();
        chk({tag, ".flags_q"}, {28'b0, flags_q}, {28'b0, exp_flags});
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] fn,
                                         input logic [4:0] sh);
        return {6'h00, 5'd9, 5'd10, 5'd8, sh, fn};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v = corner[$urandom_range(0, 4)];
        return v;
    endfunction

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < DEPTH; i++) smem[i] = 32'h0;
        masterReset = 1'b1;
        pc          = 32'h0;
        imem_we     = 1'b0;
        imem_waddr  = '0;
        imem_wdata  = 32'h0;
        busA        = 32'h0;
        busB        = 32'h0;
        carry_in    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            imem_we    = 1'b1;
            imem_waddr = AW'(i);
            imem_wdata = 32'h0;
            tick();
        end
        imem_we     = 1'b0;
        masterReset = 1'b0;
        chk("reset.flags_q", {28'b0, flags_q}, 32'h0);

        imem_we    = 1'b1;
        imem_waddr = 8'd3;
        imem_wdata = 32'h012A_4020;
        pc         = 32'd12;
        #1;
        chk("rdw.old", instruction, 32'h0);
        tick();
        imem_we = 1'b0;
        #1;
        chk("load.ins", instruction, 32'h012A_4020);
        chk("load.op", {28'b0, alu_op}, 32'd2);
        pc = 32'h0001_0000;
        #1;
        chk("oor.ins", instruction, 32'h0);
        tick();

        run("add_ovf", mk_r(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h1, 1'b0);
        pc = pc;
        chk("add_ovf.k", {alu_out[31:0]}, 32'h8000_0000);
        chk("add_ovf.v", {30'b0, overflow, carry_out}, 32'h2);
        run("addu", mk_r(6'h21, 5'd0), 32'h7FFF_FFFF, 32'h1, 1'b0);
        chk("addu.v", {31'b0, overflow}, 32'h0);
        run("beq_eq", 32'h1109_0004, 32'h1234, 32'h1234, 1'b0);
        chk("beq_eq.k", {alu_out[30:0], zero, carry_out},
            {31'h0, 1'b1, 1'b1});
        run("beq_ne", 32'h1109_0004, 32'h0, 32'h1, 1'b0);
        chk("beq_ne.k", {alu_out[30:0], carry_out}, {31'h7FFF_FFFF, 1'b0});
        run("slt", mk_r(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("slt.k", alu_out, 32'd1);
        run("sltu", mk_r(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("sltu.k", alu_out, 32'd0);
        run("sra", mk_r(6'h03, 5'd4), 32'h0, 32'h8000_0000, 1'b0);
        chk("sra.k", alu_out, 32'hF800_0000);
        run("srl", mk_r(6'h02, 5'd4), 32'h0, 32'h8000_0000, 1'b0);
        chk("srl.k", alu_out, 32'h0800_0000);
        run("sllv", mk_r(6'h04, 5'd7), 32'd33, 32'h1, 1'b0);
        chk("sllv.k", alu_out, 32'd2);

        run("ill", 32'hFC00_0000, 32'h5, 32'h6, 1'b0);
        chk("ill.k", {27'b0, illegal, alu_op}, {27'b0, 1'b1, 4'd2});
        chk("ill.flags_q3", {31'b0, flags_q[3]}, 32'h1);
        masterReset = 1'b1;
        tick();
        masterReset = 1'b0;
        chk("rst.flags_q", {28'b0, flags_q}, 32'h0);

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 2))
                0: ins = {6'h00, ins[25:6], r_fn[$urandom_range(0, 15)]};
                1: ins = {i_op[$urandom_range(0, 11)], ins[25:0]};
                default: ;
            endcase
            run("rand", ins, pick(), pick(), 1'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                masterReset = 1'b1;
                tick();
                masterReset = 1'b0;
                chk("rand.rst", {28'b0, flags_q}, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
